// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared types, constants and float<->Q2.21 conversion helpers for the CORDIC cosine block
package cordic_pkg;

    localparam int FIX_W    = 23;
    localparam int FRAC_W   = 21;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;
    localparam int ATAN_N   = 16;

    typedef logic signed [FIX_W-1:0] fix_t;

    localparam fix_t CORDIC_K = 23'sh136E95;
    localparam fix_t FIX_SAT  = 23'sh3FFFFF;

    // atan(2^-i), truncated Q2.21
    localparam fix_t ATAN_TABLE [ATAN_N] = '{
        23'sh1921FB, 23'sh0ED633, 23'sh07D6DD, 23'sh03FAB7,
        23'sh01FF55, 23'sh00FFEA, 23'sh007FFD, 23'sh003FFF,
        23'sh001FFF, 23'sh000FFF, 23'sh0007FF, 23'sh0003FF,
        23'sh0001FF, 23'sh0000FF, 23'sh00007F, 23'sh00003F
    };

    // Magnitude-only input: value = {1,man} * 2^(exp-127-23), placed so bit 21 weighs 1.0
    function automatic fix_t float_to_fix(input logic [EXP_W+MAN_W-1:0] mag_bits);
        logic [EXP_W-1:0] e;
        logic [MAN_W:0]   m;
        fix_t             r;
        e = mag_bits[EXP_W+MAN_W-1:MAN_W];
        m = {1'b1, mag_bits[MAN_W-1:0]};
        if (e >= 8'(EXP_BIAS + 1)) begin
            r = FIX_SAT;
        end else if (e < 8'(EXP_BIAS - FRAC_W)) begin
            r = '0;
        end else begin
            r = fix_t'(m >> (8'(EXP_BIAS + 2) - e));
        end
        return r;
    endfunction

    function automatic logic [31:0] fix_to_float(input fix_t v);
        logic [FIX_W-1:0] mag;
        logic [FIX_W:0]   norm;
        logic [EXP_W-1:0] e;
        logic [31:0]      r;
        int               pos;
        mag  = v[FIX_W-1] ? FIX_W'(-v) : FIX_W'(v);
        pos  = -1;
        for (int i = 0; i < FIX_W; i++) begin
            if (mag[i]) pos = i;
        end
        norm = '0;
        e    = '0;
        if (pos < 0) begin
            r = '0;
        end else begin
            norm = {1'b0, mag} << (FIX_W - pos);
            e    = 8'(EXP_BIAS + pos - FRAC_W);
            r    = {v[FIX_W-1], e, norm[MAN_W-1:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/cordic_cosine_if.sv
// rtl/cordic_cosine_if.sv - processor-side handshake bundle; floatingPoint_sine exists only with COSINE_SINE_OUT_EN
interface cordic_cosine_if;

    logic        clk_en;
    logic        start;
    logic [31:0] floatingPoint_theta;
    logic        done;
    logic [31:0] floatingPoint_result;
`ifdef COSINE_SINE_OUT_EN
    logic [31:0] floatingPoint_sine;
`endif

`ifdef COSINE_SINE_OUT_EN
    modport master (
        output clk_en, start, floatingPoint_theta,
        input  done, floatingPoint_result, floatingPoint_sine
    );
    modport slave (
        input  clk_en, start, floatingPoint_theta,
        output done, floatingPoint_result, floatingPoint_sine
    );
`else
    modport master (
        output clk_en, start, floatingPoint_theta,
        input  done, floatingPoint_result
    );
    modport slave (
        input  clk_en, start, floatingPoint_theta,
        output done, floatingPoint_result
    );
`endif

endinterface

// File: rtl/cordic_core.sv
// rtl/cordic_core.sv - rotation-mode CORDIC x/y/z registers with ITER_PER_CYCLE unrolled stages; y_next port only with COSINE_SINE_OUT_EN
module cordic_core
    import cordic_pkg::*;
#(
    parameter int ITERATIONS     = 16,
    parameter int ITER_PER_CYCLE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_en,
    input  logic load,
    input  fix_t z_in,
    output logic finishing,
`ifdef COSINE_SINE_OUT_EN
    output fix_t y_next,
`endif
    output fix_t x_next
);

    localparam int               CNT_W      = $clog2(ITERATIONS);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(ITERATIONS - ITER_PER_CYCLE);
    localparam logic [CNT_W-1:0] COUNT_STEP = CNT_W'(ITER_PER_CYCLE);

    fix_t             x, y, z;
    logic [CNT_W-1:0] count;
    logic             busy;

    fix_t             xs [ITER_PER_CYCLE+1];
    fix_t             ys [ITER_PER_CYCLE+1];
    fix_t             zs [ITER_PER_CYCLE+1];
    logic [CNT_W-1:0] stage_idx;

    // Drive z toward zero; z >= 0 rotates positively
    always_comb begin
        stage_idx = '0;
        xs[0]     = x;
        ys[0]     = y;
        zs[0]     = z;
        for (int k = 0; k < ITER_PER_CYCLE; k++) begin
            stage_idx = count + CNT_W'(k);
            if (zs[k][FIX_W-1]) begin
                xs[k+1] = xs[k] + (ys[k] >>> stage_idx);
                ys[k+1] = ys[k] - (xs[k] >>> stage_idx);
                zs[k+1] = zs[k] + ATAN_TABLE[stage_idx];
            end else begin
                xs[k+1] = xs[k] - (ys[k] >>> stage_idx);
                ys[k+1] = ys[k] + (xs[k] >>> stage_idx);
                zs[k+1] = zs[k] - ATAN_TABLE[stage_idx];
            end
        end
    end

    assign finishing = busy && (count == LAST_COUNT);
    assign x_next    = xs[ITER_PER_CYCLE];
`ifdef COSINE_SINE_OUT_EN
    assign y_next    = ys[ITER_PER_CYCLE];
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            x     <= '0;
            y     <= '0;
            z     <= '0;
            count <= '0;
            busy  <= 1'b0;
        end else if (clk_en) begin
            if (load) begin
                x     <= CORDIC_K;
                y     <= '0;
                z     <= z_in;
                count <= '0;
                busy  <= 1'b1;
            end else if (busy) begin
                x <= xs[ITER_PER_CYCLE];
                y <= ys[ITER_PER_CYCLE];
                z <= zs[ITER_PER_CYCLE];
                if (finishing) begin
                    count <= '0;
                    busy  <= 1'b0;
                end else begin
                    count <= count + COUNT_STEP;
                end
            end
        end
    end

endmodule

// File: rtl/cordic_cosine.sv
// rtl/cordic_cosine.sv - float cos(theta) top: conversion, start/done handshake, result register; COSINE_SINE_OUT_EN adds sine output
module cordic_cosine
    import cordic_pkg::*;
#(
    parameter int ITERATIONS     = 16,
    parameter int ITER_PER_CYCLE = 4
) (
    input  logic            clk,
    input  logic            reset,
    cordic_cosine_if.slave  bus
);

    fix_t        theta_fix;
    fix_t        x_next;
    logic        finishing;
    logic        complete;
    logic        done_q;
    logic [31:0] result_q;

    // cos is even: only the magnitude bits feed the rotation
    assign theta_fix = float_to_fix(bus.floatingPoint_theta[30:0]);
    // A start on the finishing edge restarts and suppresses the stale result
    assign complete  = finishing && !bus.start;

`ifdef COSINE_SINE_OUT_EN
    fix_t        y_next;
    logic        theta_sign;
    logic [31:0] sine_raw;
    logic [31:0] sine_q;

    assign sine_raw = fix_to_float(y_next);
    assign bus.floatingPoint_sine = sine_q;
`endif

    cordic_core #(
        .ITERATIONS     (ITERATIONS),
        .ITER_PER_CYCLE (ITER_PER_CYCLE)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (bus.clk_en),
        .load      (bus.start),
        .z_in      (theta_fix),
        .finishing (finishing),
`ifdef COSINE_SINE_OUT_EN
        .y_next    (y_next),
`endif
        .x_next    (x_next)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            done_q   <= 1'b0;
            result_q <= '0;
`ifdef COSINE_SINE_OUT_EN
            sine_q     <= '0;
            theta_sign <= 1'b0;
`endif
        end else if (bus.clk_en) begin
            done_q <= complete;
            if (complete) begin
                result_q <= fix_to_float(x_next);
            end
`ifdef COSINE_SINE_OUT_EN
            if (bus.start) begin
                theta_sign <= bus.floatingPoint_theta[31];
            end
            if (complete) begin
                sine_q <= (theta_sign && (sine_raw[30:0] != '0)) ?
                          {~sine_raw[31], sine_raw[30:0]} : sine_raw;
            end
`endif
        end
    end

    assign bus.done                 = done_q;
    assign bus.floatingPoint_result = result_q;

endmodule

// File: tb/tb_cordic_cosine.sv
// tb/tb_cordic_cosine.sv - scoreboard bench for cordic_cosine; checks sine too when COSINE_SINE_OUT_EN is defined
module tb_cordic_cosine;

    localparam real TOL = 1.0 / 16384.0;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cordic_cosine_if bus ();

    cordic_cosine dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] theta;
        real         c;
        real         s;
    } exp_t;

    exp_t sb [$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        e = int'(b[30:23]);
        if (e == 0) return 0.0;
        m = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
        return b[31] ? -m : m;
    endfunction

    function automatic exp_t model(input logic [31:0] th);
        exp_t e;
        e.theta = th;
        e.c     = $cos(f2r(th));
        e.s     = $sin(f2r(th));
        return e;
    endfunction

    function automatic bit close(input real a, input real b);
        return ((a > b) ? a - b : b - a) <= TOL;
    endfunction

    task automatic check(input string name, input bit ok, input real act, input real req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s actual=%g required=%g", name, act, req);
    endtask

    initial begin : monitor
        bit   prev_done;
        exp_t e;
        real  r;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.done && !prev_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1'b0, 1.0, 0.0);
                end else begin
                    e = sb.pop_front();
                    r = f2r(bus.floatingPoint_result);
                    check($sformatf("cos_%h", e.theta), close(r, e.c), r, e.c);
`ifdef COSINE_SINE_OUT_EN
                    r = f2r(bus.floatingPoint_sine);
                    check($sformatf("sin_%h", e.theta), close(r, e.s), r, e.s);
`endif
                end
            end
            prev_done = bus.done;
        end
    end

    // Drive start for the edge following this call; leaves us 1 time unit after that edge
    task automatic issue(input logic [31:0] th);
        bus.start               = 1'b1;
        bus.floatingPoint_theta = th;
        sb.push_back(model(th));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Count negedges since the load edge until done; optionally gate clk_en for 3 edges after negedge drop_at
    task automatic wait_done(input int n0, input int drop_at, output int n);
        n = n0;
        forever begin
            @(negedge clk);
            n++;
            if (bus.done) break;
            if (n >= n0 + 40) begin
                check("done_timeout", 1'b0, real'(n), 0.0);
                bus.clk_en = 1'b1;
                break;
            end
            if (n == drop_at)     bus.clk_en = 1'b0;
            if (n == drop_at + 3) bus.clk_en = 1'b1;
        end
    endtask

    task automatic run_one(input logic [31:0] th, input int drop_at, input int lat);
        int n;
        issue(th);
        wait_done(0, drop_at, n);
        check($sformatf("latency_%h", th), n == lat, real'(n), real'(lat));
        repeat (2) @(negedge clk);
    endtask

    // Restart with th2 so that its load edge is the edge after negedge k of the first run
    task automatic restart_at(input logic [31:0] th1, input logic [31:0] th2, input int k);
        int n;
        issue(th1);
        n = 0;
        while (n < k) begin
            @(negedge clk);
            n++;
        end
        void'(sb.pop_back());
        issue(th2);
        wait_done(k, -1, n);
        check($sformatf("restart_latency_%0d", k), n == k + 5, real'(n), real'(k + 5));
        repeat (2) @(negedge clk);
    endtask

    initial begin : stimulus
        bit          saw;
        logic [31:0] th;
        logic [7:0]  e;
        logic [22:0] m;

        bus.clk_en              = 1'b1;
        bus.start               = 1'b0;
        bus.floatingPoint_theta = '0;
        reset                   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_done", bus.done == 1'b0, real'(bus.done), 0.0);
        check("reset_result", bus.floatingPoint_result == 32'h0, real'(bus.floatingPoint_result), 0.0);
        reset = 1'b1;
        @(negedge clk);

        run_one(32'hBF800000, -1, 5);
        run_one(32'h3F800000, -1, 5);
        run_one(32'h00000000, -1, 5);
        run_one(32'h3F000000, -1, 5);
        run_one(32'h3FC90FDA, -1, 5);

        run_one(32'h3F800000, 2, 8);

        // done must hold while clk_en is low, then clear on the next enabled edge
        issue(32'h3F000000);
        begin
            int n;
            wait_done(0, -1, n);
        end
        bus.clk_en = 1'b0;
        repeat (3) @(negedge clk);
        check("done_hold_no_clk_en", bus.done == 1'b1, real'(bus.done), 1.0);
        bus.clk_en = 1'b1;
        @(negedge clk);
        check("done_clears", bus.done == 1'b0, real'(bus.done), 0.0);
        repeat (2) @(negedge clk);

        // Reset sampled at E2 aborts the computation
        issue(32'h3F800000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        saw   = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) saw = 1'b1;
        end
        check("reset_abort_no_done", saw == 1'b0, real'(saw), 0.0);
        check("reset_abort_result", bus.floatingPoint_result == 32'h0,
              real'(bus.floatingPoint_result), 0.0);
        run_one(32'h3F000000, -1, 5);

        restart_at(32'h3F800000, 32'h3F000000, 2);
        restart_at(32'h3F800000, 32'h3F000000, 4);
        restart_at(32'h3F000000, 32'hBF800000, 1);

        for (int i = 0; i < 24; i++) begin
            e  = 8'($urandom_range(127, 100));
            m  = (e == 8'd127) ? 23'($urandom_range(32'h490FDA, 0)) : 23'($urandom());
            th = {1'($urandom_range(1, 0)), e, m};
            run_one(th, -1, 5);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size() == 0, real'(sb.size()), 0.0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
